otter_br_target_unit: RTL and testbench

OTTER_BR_TARGET_UNIT -- requirements
Module: otter_br_target_unit

---
 rtl/otter_br_target_unit.sv | 117 +++++++++++
 tb/tb_otter_br_target_unit.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/otter_br_target_unit.sv
// otter_br_target_unit: branch/jump target computation with a return-address stack and one result register.
// Optional macro OTTER_BR_MISALIGN_EN adds a registered target-misalignment flag.
module otter_br_target_unit #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] imm,
    input  logic            rd_link,
    input  logic            rs1_link,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pred,
    output logic            out_pred_valid,
    output logic            out_misalign
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [1:0] OP_JAL  = 2'd1;
    localparam logic [1:0] OP_JALR = 2'd2;
    localparam logic [1:0] OP_NONE = 2'd3;

    logic            xfer, push, pop, hit;
    logic [XLEN-1:0] target, link_addr, top;
    logic [PW-1:0]   tp_q, tp_d, top_idx;
    logic [PW:0]     cnt_q, cnt_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_d [RAS_DEPTH];
    logic            valid_q, valid_d, pred_valid_q, pred_valid_d;
    logic [XLEN-1:0] target_q, target_d, pred_q, pred_d;

    assign in_ready  = !valid_q | out_ready;
    assign xfer      = in_valid & in_ready;
    assign link_addr = pc + XLEN'(4);
    assign top_idx   = tp_q - PW'(1);
    assign top       = ras_q[top_idx];
    assign push      = xfer & rd_link & (op == OP_JAL | op == OP_JALR);
    assign pop       = xfer & rs1_link & (op == OP_JALR);
    assign hit       = pop & (cnt_q != '0);

    always_comb begin
        target = op == OP_JALR ? (rs1 + imm) & ~XLEN'(1) : op == OP_NONE ? '0 : pc + imm;
    end

    // tp points at the next free slot; a push on a full stack wraps onto the oldest entry
    always_comb begin
        ras_d = ras_q;
        tp_d  = tp_q;
        cnt_d = cnt_q;
        if (hit) begin
            tp_d  = top_idx;
            cnt_d = cnt_q - (PW+1)'(1);
        end
        if (push) begin
            ras_d[tp_d] = link_addr;
            tp_d        = tp_d + PW'(1);
            cnt_d       = cnt_d == (PW+1)'(RAS_DEPTH) ? cnt_d : cnt_d + (PW+1)'(1);
        end
    end

    always_comb begin
        valid_d      = xfer | (valid_q & !out_ready);
        target_d     = xfer ? target : target_q;
        pred_valid_d = xfer ? hit : pred_valid_q;
        pred_d       = xfer ? (hit ? top : '0) : pred_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            target_q     <= '0;
            pred_q       <= '0;
            pred_valid_q <= 1'b0;
            tp_q         <= '0;
            cnt_q        <= '0;
        end else begin
            valid_q      <= valid_d;
            target_q     <= target_d;
            pred_q       <= pred_d;
            pred_valid_q <= pred_valid_d;
            tp_q         <= tp_d;
            cnt_q        <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign out_valid      = valid_q;
    assign out_target     = target_q;
    assign out_pred       = pred_q;
    assign out_pred_valid = pred_valid_q;

`ifdef OTTER_BR_MISALIGN_EN
    logic mis_q, mis_d;

    always_comb begin
        mis_d = !xfer ? mis_q : op == OP_JALR ? target[1] : op == OP_NONE ? 1'b0 : |target[1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mis_q <= 1'b0;
        else     mis_q <= mis_d;
    end

    assign out_misalign = mis_q;
`else
    assign out_misalign = 1'b0;
`endif
endmodule

// File: tb/tb_otter_br_target_unit.sv
// tb_otter_br_target_unit: directed vector table, hand sequences for stall/reset,
// then randomized traffic against a queue-based return-stack reference model.
module tb_otter_br_target_unit;
    localparam int D = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, rd_link = 1'b0, rs1_link = 1'b0;
    logic [1:0]  op = 2'd3;
    logic [31:0] pc = '0, rs1 = '0, imm = '0;
    logic        out_valid, out_ready = 1'b1, out_pred_valid, out_misalign;
    logic [31:0] out_target, out_pred;

    int vectors = 0, miscompares = 0;

`ifdef OTTER_BR_MISALIGN_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    otter_br_target_unit #(.XLEN(32), .RAS_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .pc(pc),
        .rs1(rs1), .imm(imm), .rd_link(rd_link), .rs1_link(rs1_link), .out_valid(out_valid),
        .out_ready(out_ready), .out_target(out_target), .out_pred(out_pred),
        .out_pred_valid(out_pred_valid), .out_misalign(out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] pc, rs1, imm;
        logic        rdl, rsl;
        logic [31:0] t, p;
        logic        pv;
    } vec_t;

    vec_t tbl[21];

    logic [31:0] ras_m[$];
    logic        m_valid, m_pv, m_m;
    logic [31:0] m_t, m_p;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic mis_exp(input logic [1:0] o, input logic [31:0] t);
        return MIS_EN && (o == 2'd2 ? t[1] : o == 2'd3 ? 1'b0 : (t[1] | t[0]));
    endfunction

    function automatic vec_t mk(input logic [1:0] o, input logic [31:0] p, input logic [31:0] r,
                                input logic [31:0] i, input logic rdl, input logic rsl,
                                input logic [31:0] t, input logic [31:0] pr, input logic pv);
        vec_t v;
        v.op = o; v.pc = p; v.rs1 = r; v.imm = i; v.rdl = rdl; v.rsl = rsl;
        v.t = t; v.p = pr; v.pv = pv;
        return v;
    endfunction

    task automatic drive(input logic [1:0] o, input logic [31:0] p, input logic [31:0] r,
                         input logic [31:0] i, input logic rdl, input logic rsl);
        in_valid = 1'b1; op = o; pc = p; rs1 = r; imm = i; rd_link = rdl; rs1_link = rsl;
    endtask

    // Reference model: the stack is a queue, newest at the back, capped at D entries
    task automatic model_apply();
        logic [31:0] t;
        t = op == 2'd2 ? ((rs1 + imm) & 32'hFFFF_FFFE) : op == 2'd3 ? 32'h0 : pc + imm;
        m_valid = 1'b1; m_t = t; m_m = mis_exp(op, t); m_pv = 1'b0; m_p = '0;
        if (op == 2'd2 && rs1_link && ras_m.size() > 0) begin
            m_pv = 1'b1;
            m_p  = ras_m.pop_back();
        end
        if ((op == 2'd1 || op == 2'd2) && rd_link) begin
            ras_m.push_back(pc + 32'd4);
            if (ras_m.size() > D) void'(ras_m.pop_front());
        end
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".valid"}, out_valid, m_valid);
        if (m_valid) begin
            check({tag, ".target"}, out_target, m_t);
            check({tag, ".pred"}, out_pred, m_p);
            check({tag, ".pred_valid"}, out_pred_valid, m_pv);
            check({tag, ".misalign"}, out_misalign, m_m);
        end
    endtask

    initial begin
        tbl[0]  = mk(2'd0, 32'h100, 32'h0,    32'hFFFF_FFF8, 0, 0, 32'hF8,   32'h0,  0);
        tbl[1]  = mk(2'd2, 32'h0,   32'h2001, 32'h4,         0, 0, 32'h2004, 32'h0,  0);
        tbl[2]  = mk(2'd2, 32'h0,   32'h2002, 32'h0,         0, 0, 32'h2002, 32'h0,  0);
        tbl[3]  = mk(2'd1, 32'h40,  32'h0,    32'h10,        1, 0, 32'h50,   32'h0,  0);
        tbl[4]  = mk(2'd2, 32'h0,   32'h44,   32'h0,         0, 1, 32'h44,   32'h44, 1);
        tbl[5]  = mk(2'd2, 32'h0,   32'h44,   32'h0,         0, 1, 32'h44,   32'h0,  0);
        tbl[6]  = mk(2'd1, 32'h0,   32'h0,    32'h8,         1, 0, 32'h8,    32'h0,  0);
        tbl[7]  = mk(2'd1, 32'h10,  32'h0,    32'h8,         1, 0, 32'h18,   32'h0,  0);
        tbl[8]  = mk(2'd1, 32'h20,  32'h0,    32'h8,         1, 0, 32'h28,   32'h0,  0);
        tbl[9]  = mk(2'd1, 32'h30,  32'h0,    32'h8,         1, 0, 32'h38,   32'h0,  0);
        tbl[10] = mk(2'd1, 32'h40,  32'h0,    32'h8,         1, 0, 32'h48,   32'h0,  0);
        tbl[11] = mk(2'd2, 32'h0,   32'h100,  32'h0,         0, 1, 32'h100,  32'h44, 1);
        tbl[12] = mk(2'd2, 32'h0,   32'h100,  32'h0,         0, 1, 32'h100,  32'h34, 1);
        tbl[13] = mk(2'd2, 32'h0,   32'h100,  32'h0,         0, 1, 32'h100,  32'h24, 1);
        tbl[14] = mk(2'd2, 32'h0,   32'h100,  32'h0,         0, 1, 32'h100,  32'h14, 1);
        tbl[15] = mk(2'd2, 32'h0,   32'h100,  32'h0,         0, 1, 32'h100,  32'h0,  0);
        tbl[16] = mk(2'd3, 32'h123, 32'h55,   32'h77,        1, 1, 32'h0,    32'h0,  0);
        tbl[17] = mk(2'd2, 32'h200, 32'h300,  32'h4,         1, 1, 32'h304,  32'h0,  0);
        tbl[18] = mk(2'd2, 32'h500, 32'h301,  32'h0,         1, 1, 32'h300,  32'h204, 1);
        tbl[19] = mk(2'd2, 32'h0,   32'h13,   32'h0,         0, 1, 32'h12,   32'h504, 1);
        tbl[20] = mk(2'd2, 32'h0,   32'h13,   32'h0,         0, 1, 32'h12,   32'h0,  0);

        #3;
        check("rst.valid", out_valid, 0);
        check("rst.target", out_target, 0);
        check("rst.pred", out_pred, 0);
        check("rst.pred_valid", out_pred_valid, 0);
        check("rst.misalign", out_misalign, 0);
        check("rst.in_ready", in_ready, 1);
        rst = 1'b0;
        step();

        foreach (tbl[k]) begin
            drive(tbl[k].op, tbl[k].pc, tbl[k].rs1, tbl[k].imm, tbl[k].rdl, tbl[k].rsl);
            step();
            check($sformatf("tbl%0d.valid", k), out_valid, 1);
            check($sformatf("tbl%0d.target", k), out_target, tbl[k].t);
            check($sformatf("tbl%0d.pred", k), out_pred, tbl[k].p);
            check($sformatf("tbl%0d.pred_valid", k), out_pred_valid, tbl[k].pv);
            check($sformatf("tbl%0d.misalign", k), out_misalign, mis_exp(tbl[k].op, tbl[k].t));
        end

        // Backpressure: a held result must not move and a stalled pop must not touch the stack
        drive(2'd1, 32'h600, 32'h0, 32'h20, 1, 0);
        step();
        check("bp.first_target", out_target, 32'h620);
        drive(2'd2, 32'h0, 32'h700, 32'h0, 0, 1);
        out_ready = 1'b0;
        #1;
        check("bp.in_ready_low", in_ready, 0);
        for (int s = 0; s < 2; s++) begin
            step();
            check("bp.hold_valid", out_valid, 1);
            check("bp.hold_target", out_target, 32'h620);
            check("bp.hold_pred_valid", out_pred_valid, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_high", in_ready, 1);
        step();
        check("bp.new_target", out_target, 32'h700);
        check("bp.new_pred", out_pred, 32'h604);
        check("bp.new_pred_valid", out_pred_valid, 1);
        in_valid = 1'b0;
        step();
        check("bp.drain_valid", out_valid, 0);

        // Asynchronous reset between edges discards the held result and empties the stack
        drive(2'd1, 32'h800, 32'h0, 32'h0, 1, 0);
        step();
        check("ar.valid_before", out_valid, 1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("ar.valid", out_valid, 0);
        check("ar.target", out_target, 0);
        check("ar.in_ready", in_ready, 1);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        drive(2'd2, 32'h0, 32'h900, 32'h0, 0, 1);
        step();
        check("ar.pop_valid", out_valid, 1);
        check("ar.pop_pred_valid", out_pred_valid, 0);
        check("ar.pop_pred", out_pred, 0);

        in_valid = 1'b0;
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        m_valid = 1'b0; m_t = '0; m_p = '0; m_pv = 1'b0; m_m = 1'b0;
        ras_m.delete();
        step();

        for (int i = 0; i < 600; i++) begin
            logic xfer;
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            op        = 2'($urandom_range(0, 3));
            pc        = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 255)) << 2;
            rs1       = $urandom;
            imm       = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, 63)) - 32'd32;
            rd_link   = $urandom_range(0, 1) == 1;
            rs1_link  = $urandom_range(0, 1) == 1;
            #1;
            check("rnd.in_ready", in_ready, !m_valid | out_ready);
            xfer = in_valid & (!m_valid | out_ready);
            @(posedge clk);
            #1;
            if (xfer) model_apply();
            else if (m_valid && out_ready) m_valid = 1'b0;
            check_outs("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
